// File: rtl/mb_sync_tx.sv
// Source-side transmitter for a four-phase req/ack multibit level-synchronizer crossing.
// Optional handshake-phase timeout: define MB_SYNC_TX_TIMEOUT_EN.
module mb_sync_tx #(
  parameter int NB      = 8,
  parameter int NSYNC   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic          i_src_clock,
  input  logic          i_reset,
  input  logic [NB-1:0] i_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [NB-1:0] o_data,
  output logic          o_req,
  input  logic          i_ack,
  output logic          o_done,
  output logic          o_timeout,
  output logic [1:0]    o_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK_LOW = 2'd2
  } state_t;

  if (NSYNC < 2 || TIMEOUT < 2) begin : g_bad_param
    $error("mb_sync_tx: NSYNC and TIMEOUT must both be >= 2");
  end

  state_t          state;
  state_t          state_next;
  logic [NSYNC-1:0] ack_ff;
  logic            ack_sync;
  logic            accept;
  logic            abort;
  logic            expired;
  logic            req_next;
  logic [NB-1:0]   data_next;
  logic            done_next;
  logic            timeout_next;

  // Handshake (valid/ready): a word transfers on a rising edge where
  // i_valid && o_ready; upstream holds i_data/i_valid until that edge.
  assign o_ready = (state == IDLE) && !ack_sync && !i_reset;
  assign accept  = i_valid && o_ready;
  assign o_state = state;

  // i_ack is asynchronous; only the last stage of this chain is ever used.
  always_ff @(posedge i_src_clock) begin
    if (i_reset) ack_ff <= '0;
    else         ack_ff <= {ack_ff[NSYNC-2:0], i_ack};
  end
  assign ack_sync = ack_ff[NSYNC-1];

`ifdef MB_SYNC_TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] phase_cnt;

  // Counts cycles spent in the current handshake phase.
  always_ff @(posedge i_src_clock) begin
    if (i_reset || (state_next != state)) phase_cnt <= '0;
    else if (state != IDLE)               phase_cnt <= phase_cnt + 1'b1;
  end
  assign expired = (phase_cnt == CW'(TIMEOUT - 1));
`else
  assign expired = 1'b0;
`endif

  // State register plus the registered outputs.
  always_ff @(posedge i_src_clock) begin
    if (i_reset) begin
      state     <= IDLE;
      o_req     <= 1'b0;
      o_data    <= '0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_next;
      o_req     <= req_next;
      o_data    <= data_next;
      o_done    <= done_next;
      o_timeout <= timeout_next;
    end
  end

  // Next-state logic; a real ack transition always wins over an expiring timer.
  always_comb begin
    state_next = state;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = REQ;
      end
      REQ: begin
        if (ack_sync) begin
          state_next = ACK_LOW;
        end else if (expired) begin
          state_next = IDLE;
          abort      = 1'b1;
        end
      end
      ACK_LOW: begin
        if (!ack_sync) begin
          state_next = IDLE;
        end else if (expired) begin
          state_next = IDLE;
          abort      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: o_req is high exactly while in REQ; o_data moves only on accept.
  always_comb begin
    req_next     = (state_next == REQ);
    data_next    = accept ? i_data : o_data;
    done_next    = (state == ACK_LOW) && (state_next == IDLE) && !abort;
    timeout_next = abort;
  end

endmodule

// File: tb/tb_mb_sync_tx.sv
// Self-checking bench for mb_sync_tx: directed scenarios plus randomized traffic
// against a transaction-level reference model with a word scoreboard.
module tb_mb_sync_tx;
  localparam int NB      = 8;
  localparam int NSYNC   = 2;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          i_reset;
  logic [NB-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic [NB-1:0] o_data;
  logic          o_req;
  logic          i_ack;
  logic          o_done;
  logic          o_timeout;
  logic [1:0]    o_state;

  always #5 clk = ~clk;

  mb_sync_tx #(.NB(NB), .NSYNC(NSYNC), .TIMEOUT(TIMEOUT)) dut (
    .i_src_clock(clk),
    .i_reset    (i_reset),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_req      (o_req),
    .i_ack      (i_ack),
    .o_done     (o_done),
    .o_timeout  (o_timeout),
    .o_state    (o_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- destination model ----------------
  // Either follows a manually set level, or mirrors o_req after a random delay.
  logic dest_en  = 1'b0;
  logic ack_man  = 1'b0;
  int   dly      = 2;
  int   dly_cnt  = 0;

  initial i_ack = 1'b0;
  always @(posedge clk) begin
    #2;
    if (!dest_en) begin
      i_ack = ack_man;
      dly_cnt = 0;
    end else if (i_ack !== o_req) begin
      if (dly_cnt >= dly) begin
        i_ack   = o_req;
        dly     = $urandom_range(0, 6);
        dly_cnt = 0;
      end else begin
        dly_cnt++;
      end
    end else begin
      dly_cnt = 0;
    end
  end

  // ---------------- reference model ----------------
  // ack_hist holds the last NSYNC sampled i_ack values; the oldest is what the
  // transmitter is allowed to act on.
  logic          ack_hist[$];
  logic [NB-1:0] exp_q[$];
  logic          m_busy, m_wait_high, m_done, m_to, ack_s, rdy;
  logic [NB-1:0] m_data;
  int            timer;

  task automatic model_reset();
    m_busy = 1'b0; m_wait_high = 1'b0; m_done = 1'b0; m_to = 1'b0;
    m_data = '0; timer = 0;
    ack_hist.delete();
    for (int i = 0; i < NSYNC; i++) ack_hist.push_back(1'b0);
    exp_q.delete();
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (i_reset) begin
      model_reset();
    end else begin
      ack_s  = ack_hist[0];
      rdy    = !m_busy && !ack_s;
      m_done = 1'b0;
      m_to   = 1'b0;
      if (!m_busy) begin
        if (i_valid && rdy) begin
          m_data      = i_data;
          m_busy      = 1'b1;
          m_wait_high = 1'b1;
          timer       = 0;
          exp_q.push_back(i_data);
        end
      end else if (m_wait_high ? ack_s : !ack_s) begin
        if (m_wait_high) m_wait_high = 1'b0;
        else begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
        timer = 0;
      end
`ifdef MB_SYNC_TX_TIMEOUT_EN
      else if (timer == TIMEOUT - 1) begin
        m_busy = 1'b0; m_wait_high = 1'b0; m_to = 1'b1; timer = 0;
      end else begin
        timer++;
      end
`endif
      ack_hist.push_back(i_ack);
      void'(ack_hist.pop_front());
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("o_ready",   o_ready,   !m_busy && !ack_hist[0] && !i_reset);
      check("o_req",     o_req,     m_busy && m_wait_high);
      check("o_data",    o_data,    m_data);
      check("o_done",    o_done,    m_done);
      check("o_timeout", o_timeout, m_to);
      check("done_and_timeout", o_done && o_timeout, 1'b0);
      if (o_done === 1'b1 || o_timeout === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_word: completion with no outstanding word, got 0x%0h at %0t", o_data, $time);
        end else begin
          check("sb_word", o_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (o_done !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    check({name, "_done_seen"}, o_done, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_data = '0;
    tick();
    chk_en = 1'b1;

    // Reset
    check("rst_req",   o_req,   1'b0);
    check("rst_data",  o_data,  8'h00);
    check("rst_ready", o_ready, 1'b0);
    check("rst_state", o_state, 2'd0);
    tick(); tick();
    i_reset = 1'b0;
    #1;
    check("rel_ready", o_ready, 1'b1);

    // Single transfer with hand-timed acknowledge
    i_data = 8'hA5; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    check("t2_req_rise", o_req, 1'b1);
    check("t2_data",     o_data, 8'hA5);
    repeat (3) tick();
    ack_man = 1'b1;
    tick(); tick();
    check("t2_req_hold", o_req, 1'b1);
    tick();
    check("t2_req_fall", o_req, 1'b0);
    repeat (3) tick();
    ack_man = 1'b0;
    tick(); tick();
    check("t2_done_early", o_done, 1'b0);
    tick();
    check("t2_done",      o_done, 1'b1);
    check("t2_done_data", o_data, 8'hA5);
    tick();
    check("t2_done_pulse", o_done, 1'b0);
    check("t2_ready_back", o_ready, 1'b1);

    // Back-pressure
    dest_en = 1'b1;
    i_data = 8'h3C; i_valid = 1'b1;
    tick();
    i_data = 8'h5A;
    check("t3_first", o_data, 8'h3C);
    wait_done("t3a");
    check("t3_hold_data", o_data, 8'h3C);
    tick();
    i_valid = 1'b0;
    check("t3_second", o_data, 8'h5A);
    check("t3_req2",   o_req,  1'b1);
    wait_done("t3b");

    // Stale acknowledge at reset release
    tick();
    dest_en = 1'b0; ack_man = 1'b1; i_reset = 1'b1;
    tick(); tick();
    i_reset = 1'b0;
    tick(); tick();
    check("t4_ready_stale", o_ready, 1'b0);
    i_data = 8'h99; i_valid = 1'b1;
    repeat (3) begin
      tick();
      check("t4_no_req",  o_req,  1'b0);
      check("t4_no_done", o_done, 1'b0);
    end
    ack_man = 1'b0;
    tick();
    check("t4_ready_e0", o_ready, 1'b0);
    tick();
    check("t4_ready_e1", o_ready, 1'b1);
    tick();
    i_valid = 1'b0;
    check("t4_req",  o_req,  1'b1);
    check("t4_data", o_data, 8'h99);
    dest_en = 1'b1;
    wait_done("t4");

    // Reset while in REQ
    tick();
    dest_en = 1'b0; ack_man = 1'b0;
    i_data = 8'h42; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    check("t5_req", o_req, 1'b1);
    tick(); tick();
    i_reset = 1'b1;
    tick();
    check("t5_req_drop", o_req,  1'b0);
    check("t5_no_done",  o_done, 1'b0);
    i_reset = 1'b0;
    i_data = 8'h11; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    check("t5_req2", o_req, 1'b1);
    dest_en = 1'b1;
    wait_done("t5");
    check("t5_data", o_data, 8'h11);

`ifdef MB_SYNC_TX_TIMEOUT_EN
    // Timeout with no acknowledge
    tick();
    dest_en = 1'b0; ack_man = 1'b0;
    i_data = 8'h77; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int k = 1; k < 16; k++) begin
      tick();
      check("t6_no_timeout", o_timeout, 1'b0);
    end
    tick();
    check("t6_timeout", o_timeout, 1'b1);
    check("t6_req",     o_req,     1'b0);
    check("t6_ready",   o_ready,   1'b1);
    check("t6_done",    o_done,    1'b0);
    check("t6_data",    o_data,    8'h77);
    tick();
    check("t6_pulse",   o_timeout, 1'b0);
    dest_en = 1'b1;
`endif

    // Randomized traffic, occasional resets
    for (int n = 0; n < 600; n++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_data  = NB'($urandom_range(0, 255));
      i_reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    i_valid = 1'b0;
    i_reset = 1'b0;
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mb_sync_tx.md
Name: mb_sync_tx

Overview:
Source-side transmitter for the multibit level-synchronizer (four-phase req/ack) crossing. Accepts a word from source-domain logic via valid/ready and captures it into a holding register. Drives a level request to the destination and waits for the returned acknowledge through an internal NSYNC-flop synchronizer. Keeps the data bus stable for the whole handshake, so the destination side can sample it safely.

Parameters:
NB, 8, data width in bits
NSYNC, 2, synchronizer depth for i_ack (legal values >= 2)
TIMEOUT, 64, cycles allowed per handshake phase before abort (used only with MB_SYNC_TX_TIMEOUT_EN)

Ports:
i_src_clock  in  1  source-domain clock; the only clock in the block
i_reset  in  1  synchronous, active-high reset
i_data  in  NB  word to transfer
i_valid  in  1  i_data is valid; the word transfers on a cycle where i_valid && o_ready
o_ready  out  1  block can accept a word this cycle
o_data  out  NB  held data driven across the crossing
o_req  out  1  level request to the destination domain
i_ack  in  1  level acknowledge from the destination; asynchronous to i_src_clock
o_done  out  1  one-cycle pulse when a handshake completes
o_timeout  out  1  one-cycle pulse when a handshake is aborted (tied 0 without the macro)

Behaviour:
- All state is updated on the rising edge of i_src_clock.
- While i_reset=1, on each clock edge: state<=IDLE, o_req<=0, o_data<=0, o_done<=0, o_timeout<=0, synchronizer flops<=0, timeout counter<=0.
- o_ready = (state==IDLE) && !ack_sync && !i_reset. This is combinational.
- ack_sync is the output of the NSYNC-stage flop chain on i_ack. Only the FSM uses ack_sync; raw i_ack never feeds logic.
- FSM states and transitions:
  - IDLE: if i_valid && o_ready, then o_data<=i_data, o_req<=1, go to REQ. Otherwise o_data holds its value.
  - REQ: o_req=1. When ack_sync=1, o_req<=0 and go to ACK_LOW.
  - ACK_LOW: o_req=0. When ack_sync=0, o_done<=1 for one cycle and go to IDLE.
- Latency:
  - o_req rises 1 edge after the accept edge.
  - o_req falls NSYNC+1 edges after the first edge that samples i_ack=1.
  - o_done asserts NSYNC+1 edges after the first edge that samples i_ack=0.
- o_data changes only on an accept edge. It is stable from o_req rise until the next accept.
- i_valid while not ready is ignored. The word is not queued; upstream must hold it until o_ready=1.
- Stale or spurious ack_sync=1 in IDLE does not change state. It holds o_ready=0 until ack_sync returns to 0.
- Reset mid-handshake: o_req drops on the reset edge and the state goes to IDLE with no o_done. If the destination still drives i_ack=1, o_ready stays 0 until ack_sync clears.
- o_done and o_timeout are never both 1 in the same cycle.

Optional Feature:
Macro MB_SYNC_TX_TIMEOUT_EN.
- Defined:
  - A counter of clog2(TIMEOUT+1) bits clears on every state change and increments each cycle in REQ or ACK_LOW.
  - When the counter reaches TIMEOUT-1 without a transition: o_req<=0, state<=IDLE, o_timeout<=1 for one cycle, no o_done.
  - o_data holds its value.
- Undefined: no counter logic; o_timeout is tied to 0 and the FSM waits indefinitely.

Test Plan:
1. Reset: i_reset=1 for 3 cycles with i_ack=0 -> o_req=0, o_data=0x00, o_ready=0 during reset; o_ready=1 on the first cycle after release.
2. Single transfer, NB=8, NSYNC=2: i_data=0xA5 with i_valid for 1 cycle; the destination model raises i_ack 4 cycles after o_req rises and drops it 4 cycles after o_req falls -> o_req high 1 edge after accept; o_req low 3 edges after i_ack is first sampled high; o_done pulses 3 edges after i_ack is first sampled low; o_data=0xA5 throughout.
3. Back-pressure: present 0x3C (accepted), then hold i_valid=1 with 0x5A during the handshake -> 0x5A is not accepted until the cycle after o_done; o_data stays 0x3C until then and then becomes 0x5A.
4. Stale ack: i_ack=1 at reset release, lowered 5 cycles later -> o_ready=0 until 2 edges after i_ack is sampled low; no o_req and no o_done before that.
5. Reset in REQ: assert i_reset while o_req=1 and i_ack=0 -> o_req=0 on the next edge, no o_done; a subsequent transfer of 0x11 completes normally.
6. Timeout (macro defined, TIMEOUT=16): accept 0x77, i_ack held at 0 -> o_timeout pulses 16 cycles after entering REQ, o_req=0, o_ready=1, o_done never asserts, o_data=0x77.
